// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial-line signals of the UART frame transmitter.
// The master modport drives the byte source side; the slave modport belongs to the transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop; each bit held Prescale clk cycles.
// Back-to-back frames are accepted at the final stop cycle so the line never idles between them.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                state_r,    state_s;
    logic [5:0]            timer_r,    timer_s;
    logic [IDX_W-1:0]      bit_idx_r,  bit_idx_s;
    logic [DATA_WIDTH-1:0] data_r,     data_s;
    logic                  par_en_r,   par_en_s;
    logic                  par_typ_r,  par_typ_s;
    logic [5:0]            prescale_r, prescale_s;
    logic                  tx_r,       tx_s;
    logic                  busy_r,     busy_s;

    logic legal_s;
    logic accept_s;
    logic wrap_s;

    assign legal_s  = (bus.Prescale == 6'd8) || (bus.Prescale == 6'd16) || (bus.Prescale == 6'd32);
    assign accept_s = bus.Data_Valid & legal_s;
    assign wrap_s   = (timer_r == (prescale_r - 6'd1));

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            timer_r    <= 6'd0;
            bit_idx_r  <= '0;
            data_r     <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            prescale_r <= 6'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            data_r     <= data_s;
            par_en_r   <= par_en_s;
            par_typ_r  <= par_typ_s;
            prescale_r <= prescale_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state, bit timer, frame latches and next line value.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r + 6'd1;
        bit_idx_s  = bit_idx_r;
        data_s     = data_r;
        par_en_s   = par_en_r;
        par_typ_s  = par_typ_r;
        prescale_s = prescale_r;
        tx_s       = 1'b1;
        busy_s     = 1'b0;

        case (state_r)
            IDLE: begin
                timer_s = 6'd0;
                if (accept_s) begin
                    state_s    = START;
                    data_s     = bus.P_DATA;
                    par_en_s   = bus.PAR_EN;
                    par_typ_s  = bus.PAR_TYP;
                    prescale_s = bus.Prescale;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (wrap_s) begin
                    state_s   = DATA;
                    timer_s   = 6'd0;
                    bit_idx_s = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (wrap_s) begin
                    timer_s = 6'd0;
                    if (bit_idx_r == LAST_IDX) begin
                        state_s   = par_en_r ? PARITY : STOP;
                        bit_idx_s = '0;
                    end else begin
                        bit_idx_s = bit_idx_r + 1'b1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (wrap_s) begin
                    state_s = STOP;
                    timer_s = 6'd0;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (wrap_s) begin
                    timer_s = 6'd0;
                    // A request waiting at the last stop cycle chains straight into the next start bit.
                    if (accept_s) begin
                        state_s    = START;
                        data_s     = bus.P_DATA;
                        par_en_s   = bus.PAR_EN;
                        par_typ_s  = bus.PAR_TYP;
                        prescale_s = bus.Prescale;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = 6'd0;
            end
        endcase

        case (state_s)
            IDLE:    begin tx_s = 1'b1;                            busy_s = 1'b0; end
            START:   begin tx_s = 1'b0;                            busy_s = 1'b1; end
            DATA:    begin tx_s = data_s[bit_idx_s];               busy_s = 1'b1; end
            PARITY:  begin tx_s = parity_bit(data_s, par_typ_s);   busy_s = 1'b1; end
            STOP:    begin tx_s = 1'b1;                            busy_s = 1'b1; end
            default: begin tx_s = 1'b1;                            busy_s = 1'b0; end
        endcase
    end

    assign bus.TX_OUT = tx_r;
    assign bus.Busy   = busy_r;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table of single frames plus hand-written corner sequences,
// with per-cycle expected line levels held in a scoreboard queue.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b0;
    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         exp_busy;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];
    logic exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level for every clock cycle of a frame.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic par, input int ps);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        foreach (bits[b]) for (int c = 0; c < ps; c++) exp_q.push_back(bits[b]);
    endtask

    function automatic logic model_par(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps, input logic hold);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        if (!hold) begin
            #1 bus.Data_Valid = 1'b0;
        end
    endtask

    // Compare the line against the queue each cycle, then require one idle cycle.
    task automatic check_stream(input string name, input int exp_busy);
        int  busy_cnt = 0;
        bit  done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                chk({name, "_tx"}, 32'(bus.TX_OUT), 32'(exp_q.pop_front()));
                chk({name, "_busy"}, 32'(bus.Busy), 32'd1);
                busy_cnt++;
            end else begin
                chk({name, "_idle_tx"}, 32'(bus.TX_OUT), 32'd1);
                chk({name, "_idle_busy"}, 32'(bus.Busy), 32'd0);
                done = 1;
            end
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        chk({name, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  80,  1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd16, 176, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd16, 176, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 6'd32, 352, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 6'd8,  88,  1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 6'd32, 320, 1'b0};

        bus.P_DATA = 8'h00; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0; bus.Prescale = 6'd8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        rst = 1'b1;

        foreach (vecs[v]) begin
            push_frame(vecs[v].data, vecs[v].pe, vecs[v].exp_par, int'(vecs[v].ps));
            start_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].ps, 1'b0);
            check_stream($sformatf("vec%0d", v), vecs[v].exp_busy);
        end

        // Data_Valid held through the stop bit chains a second frame with no gap.
        push_frame(8'h55, 1'b0, 1'b0, 32);
        push_frame(8'h0F, 1'b0, 1'b0, 32);
        start_frame(8'h55, 1'b0, 1'b0, 6'd32, 1'b1);
        fork
            check_stream("chain", 640);
            begin
                @(negedge clk);
                bus.P_DATA = 8'h0F;
                repeat (320) @(negedge clk);
                bus.Data_Valid = 1'b0;
            end
        join

        // Requests during DATA are ignored and latched data is untouched.
        push_frame(8'h00, 1'b0, 1'b0, 8);
        start_frame(8'h00, 1'b0, 1'b0, 6'd8, 1'b0);
        fork
            check_stream("ignore", 80);
            begin
                repeat (20) @(negedge clk);
                bus.P_DATA = 8'hFF;
                bus.Data_Valid = 1'b1;
                repeat (30) @(negedge clk);
                bus.Data_Valid = 1'b0;
            end
        join

        // Reset during data bit 3 abandons the frame immediately.
        push_frame(8'hC3, 1'b0, 1'b0, 8);
        start_frame(8'hC3, 1'b0, 1'b0, 6'd8, 1'b0);
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            chk("pre_rst_tx", 32'(bus.TX_OUT), 32'(exp_q.pop_front()));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        push_frame(8'h3C, 1'b1, model_par(8'h3C, 1'b1), 16);
        start_frame(8'h3C, 1'b1, 1'b1, 6'd16, 1'b0);
        check_stream("post_rst", 176);

        // Illegal prescale is never accepted.
        @(negedge clk);
        bus.Prescale = 6'd10;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bad_ps_tx", 32'(bus.TX_OUT), 32'd1);
            chk("bad_ps_busy", 32'(bus.Busy), 32'd0);
        end
        bus.Data_Valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
